// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out receiver.
// Optional even-parity support is compiled in with SIPO_PARITY_EN.
package sipo_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned DIV_DEF   = 8;

`ifdef SIPO_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

endpackage

// File: rtl/sipo_receiver_bit_timer.sv
// Loadable down-counter that paces bit sampling; expired is high while the
// count sits at zero.
module bit_timer #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/sipo_receiver.sv
// Serial receiver: synchronizes sin, frames start/data/stop LSB-first and
// presents each good word on led. Define SIPO_PARITY_EN for an even-parity bit.
module sipo_receiver
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIV   = DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             ack,
    output logic [WIDTH-1:0] led,
    output logic             valid,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned TW   = $clog2(DIV);
    localparam int unsigned CNTW = $clog2(WIDTH);

    logic             s_meta_q, s_q;
    state_t           state_q, state_d;
    logic             tmr_load, tmr_exp;
    logic [TW-1:0]    tmr_val;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNTW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             valid_q, valid_d;
    logic             ferr_q, overrun_q, overrun_d;
    logic             shift_en, last_bit, land, err, par_bad;

    bit_timer #(.CW(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta_q <= 1'b1;
            s_q      <= 1'b1;
            state_q  <= IDLE;
        end else begin
            s_meta_q <= sin;
            s_q      <= s_meta_q;
            state_q  <= state_d;
        end
    end

    assign last_bit = (bit_cnt_q == CNTW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!s_q) state_d = START;
            START: if (tmr_exp) state_d = s_q ? IDLE : DATA;
`ifdef SIPO_PARITY_EN
            DATA:   if (tmr_exp && last_bit) state_d = PARITY;
            PARITY: if (tmr_exp) state_d = STOP;
`else
            DATA:  if (tmr_exp && last_bit) state_d = STOP;
`endif
            STOP:  if (tmr_exp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SIPO_PARITY_EN
    logic par_cap, par_err_q;
    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        shift_en = 1'b0;
        land     = 1'b0;
        err      = 1'b0;
`ifdef SIPO_PARITY_EN
        par_cap  = 1'b0;
`endif
        case (state_q)
            IDLE: if (!s_q) begin
                tmr_load = 1'b1;
                tmr_val  = TW'(DIV / 2 - 1);
            end
            START: if (tmr_exp && !s_q) begin
                tmr_load = 1'b1;
                tmr_val  = TW'(DIV - 1);
            end
            DATA: if (tmr_exp) begin
                shift_en = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = TW'(DIV - 1);
            end
`ifdef SIPO_PARITY_EN
            PARITY: if (tmr_exp) begin
                par_cap  = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = TW'(DIV - 1);
            end
`endif
            STOP: if (tmr_exp) begin
                land = s_q && !par_bad;
                err  = !(s_q && !par_bad);
            end
            default: ;
        endcase
    end

    always_comb begin
        shift_d   = shift_en ? {s_q, shift_q[WIDTH-1:1]} : shift_q;
        bit_cnt_d = (state_q == IDLE) ? '0 : (shift_en ? bit_cnt_q + CNTW'(1) : bit_cnt_q);
        led_d     = land ? shift_q : led_q;
        valid_d   = land ? 1'b1 : (ack ? 1'b0 : valid_q);
        // Acknowledge in the landing cycle consumes the old word, so no overrun.
        overrun_d = overrun_q | (land & valid_q & ~ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            led_q     <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            led_q     <= led_d;
            valid_q   <= valid_d;
            ferr_q    <= err;
            overrun_q <= overrun_d;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_err_q <= 1'b0;
        else if (par_cap)
            par_err_q <= s_q ^ (^shift_q);
    end
`endif

    assign led       = led_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver (WIDTH=16, DIV=4) with a word scoreboard.
// Define SIPO_PARITY_EN on both bench and RTL to cover the parity build.
module tb_sipo_receiver;

    localparam int WIDTH = 16;
    localparam int DIV   = 4;
`ifdef SIPO_PARITY_EN
    localparam int NB = WIDTH + 3;
`else
    localparam int NB = WIDTH + 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sin = 1'b1;
    logic             ack = 1'b0;
    logic [WIDTH-1:0] led;
    logic             valid, frame_err, overrun;

    int n_total = 0;
    int n_pass  = 0;
    int err_pulses = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] prev_led = '0;
    logic             prev_valid = 1'b0;

    sipo_receiver #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .ack       (ack),
        .led       (led),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // Scoreboard: a landed word shows up as led changing or valid rising.
    always @(negedge clk) begin
        if (rst) begin
            prev_led   = led;
            prev_valid = valid;
        end else begin
            if (frame_err === 1'b1) err_pulses++;
            if (led !== prev_led || (valid === 1'b1 && prev_valid !== 1'b1)) begin
                if (sb.size() == 0) check("sb_unexpected_word", 32'(led), 32'hFFFF_FFFF);
                else                check("sb_word", 32'(led), 32'(sb.pop_front()));
            end
            prev_led   = led;
            prev_valid = valid;
        end
    end

    task automatic drive_frame(input logic [WIDTH-1:0] d, input logic stop_b,
                               input logic par_b, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int   b;
            logic v;
            b = c / DIV;
            if (b == 0)                          v = 1'b0;
            else if (b <= WIDTH)                 v = d[b-1];
            else if (b == WIDTH + 1 && NB == WIDTH + 3) v = par_b;
            else                                 v = stop_b;
            @(posedge clk);
            #1 sin = v;
        end
    endtask

    // Returns one cycle before the stop-bit sample edge.
    task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop_b, input logic par_b);
        drive_frame(d, stop_b, par_b, NB * DIV);
        @(posedge clk);
        #1 sin = 1'b1;
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int errs_before;

        #1;
        check("rst_led", 32'(led), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // Good frame; valid must rise exactly one cycle after the stop sample.
        sb.push_back(16'hA5C3);
        send_frame(16'hA5C3, 1'b1, ^16'hA5C3);
        @(negedge clk);
        check("f1_valid_early", 32'(valid), 32'h0);
        @(negedge clk);
        check("f1_valid", 32'(valid), 32'h1);
        check("f1_led", 32'(led), 32'hA5C3);
        check("f1_frame_err", 32'(frame_err), 32'h0);
        repeat (4) @(posedge clk);

        // Word lands while ack is high: new word wins, no overrun.
        sb.push_back(16'h1357);
        send_frame(16'h1357, 1'b1, ^16'h1357);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        check("f2_valid", 32'(valid), 32'h1);
        check("f2_led", 32'(led), 32'h1357);
        check("f2_overrun", 32'(overrun), 32'h0);
        pulse_ack();
        check("f2_ack_valid", 32'(valid), 32'h0);

        // Bad stop bit.
        errs_before = err_pulses;
        send_frame(16'h00FF, 1'b0, ^16'h00FF);
        @(negedge clk);
        @(negedge clk);
        check("f3_frame_err_pulse", 32'(frame_err), 32'h1);
        @(negedge clk);
        check("f3_frame_err_clear", 32'(frame_err), 32'h0);
        check("f3_led_kept", 32'(led), 32'h1357);
        check("f3_valid_kept", 32'(valid), 32'h0);
        repeat (12) @(negedge clk);
        check("f3_err_count", 32'(err_pulses - errs_before), 32'h1);

        // One-cycle glitch must be rejected silently.
        errs_before = err_pulses;
        @(posedge clk);
        #1 sin = 1'b0;
        @(posedge clk);
        #1 sin = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch_valid", 32'(valid), 32'h0);
        check("glitch_err", 32'(err_pulses - errs_before), 32'h0);
        check("glitch_led", 32'(led), 32'h1357);

        // Two words without ack -> overrun.
        sb.push_back(16'h5A5A);
        send_frame(16'h5A5A, 1'b1, ^16'h5A5A);
        repeat (3) @(negedge clk);
        check("f4_overrun", 32'(overrun), 32'h0);
        check("f4_valid", 32'(valid), 32'h1);
        sb.push_back(16'h0F0F);
        send_frame(16'h0F0F, 1'b1, ^16'h0F0F);
        repeat (3) @(negedge clk);
        check("f5_overrun", 32'(overrun), 32'h1);
        check("f5_led", 32'(led), 32'h0F0F);
        pulse_ack();
        check("f5_ack_valid", 32'(valid), 32'h0);
        repeat (5) @(negedge clk);
        check("f5_overrun_sticky", 32'(overrun), 32'h1);

        // Reset at data bit 7 acts immediately and discards the partial word.
        drive_frame(16'hFFFF, 1'b1, 1'b0, DIV * 8);
        rst = 1'b1;
        sin = 1'b1;
        #1;
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        sb.push_back(16'h1234);
        send_frame(16'h1234, 1'b1, ^16'h1234);
        repeat (3) @(negedge clk);
        check("f6_led", 32'(led), 32'h1234);
        check("f6_valid", 32'(valid), 32'h1);
        check("f6_overrun", 32'(overrun), 32'h0);
        pulse_ack();

`ifdef SIPO_PARITY_EN
        errs_before = err_pulses;
        send_frame(16'h0001, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("par_bad_err", 32'(frame_err), 32'h1);
        check("par_bad_led", 32'(led), 32'h1234);
        check("par_bad_valid", 32'(valid), 32'h0);
        repeat (4) @(posedge clk);
        sb.push_back(16'h0001);
        send_frame(16'h0001, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("par_good_led", 32'(led), 32'h0001);
        check("par_good_valid", 32'(valid), 32'h1);
        check("par_err_count", 32'(err_pulses - errs_before), 32'h1);
`endif

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
